// File: rtl/zone_luma_stats.sv
// rtl/zone_luma_stats.sv - per-zone luminance peak/average statistics with one write burst per zone row
module zone_luma_stats #(
   parameter int ZONE_COLS   = 16,
   parameter int ZONE_ROWS   = 8,
   parameter int ZONE_W_LOG2 = 6,
   parameter int ZONE_H_LOG2 = 6
) (
   input  logic        I_clk,
   input  logic        I_rst_n,
   input  logic        I_vs,
   input  logic        I_de,
   input  logic [7:0]  I_r,
   input  logic [7:0]  I_g,
   input  logic [7:0]  I_b,
   output logic        O_sdbpflag,
   output logic        O_wr,
   output logic [9:0]  O_wtaddr,
   output logic [15:0] O_wtdina
);
   localparam int CW = (ZONE_COLS > 1) ? $clog2(ZONE_COLS) : 1;
   localparam int SW = ZONE_W_LOG2 + ZONE_H_LOG2 + 8;
   localparam int PW = 16;
   localparam logic [PW-1:0] X_LIMIT = PW'(ZONE_COLS << ZONE_W_LOG2);
   localparam logic [PW-1:0] Y_LIMIT = PW'(ZONE_ROWS << ZONE_H_LOG2);

   typedef enum logic {IDLE, DUMP} state_t;

   logic [7:0]    lum_q;
   logic          de_d_q, de_dd_q, vs_q;
   logic [PW-1:0] x_q, x_d_q, y_q;

   logic [SW-1:0] sum_q       [ZONE_COLS];
   logic [7:0]    peak_q      [ZONE_COLS];
   logic [7:0]    dump_avg_q  [ZONE_COLS];
   logic [7:0]    dump_peak_q [ZONE_COLS];
   logic [9:0]    dump_row_q;

   state_t        state_q;
   logic [CW-1:0] col_q;

   logic [7:0]    max_rg, lum_d;
   logic          vs_rise, line_end, row_end, pix_in_grid;
   logic [CW-1:0] pix_col;
   logic [9:0]    addr_d;

   always_comb begin
      max_rg = (I_r > I_g) ? I_r : I_g;
      lum_d  = (max_rg > I_b) ? max_rg : I_b;
   end

   // Line end is seen one cycle after I_de drops, once the last pixel has been accumulated.
   assign vs_rise     = I_vs & ~vs_q;
   assign line_end    = de_dd_q & ~de_d_q;
   assign row_end     = line_end && (&y_q[ZONE_H_LOG2-1:0]) && (y_q < Y_LIMIT);
   assign pix_in_grid = de_d_q && (x_d_q < X_LIMIT) && (y_q < Y_LIMIT);
   assign pix_col     = x_d_q[ZONE_W_LOG2 +: CW];
   assign addr_d      = 10'(dump_row_q * 10'(ZONE_COLS)) + 10'(col_q);

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         lum_q   <= '0;
         de_d_q  <= 1'b0;
         de_dd_q <= 1'b0;
         vs_q    <= 1'b0;
         x_q     <= '0;
         x_d_q   <= '0;
         y_q     <= '0;
      end else begin
         lum_q   <= lum_d;
         de_d_q  <= I_de;
         de_dd_q <= de_d_q;
         vs_q    <= I_vs;
         x_d_q   <= x_q;
         // Position counters saturate so over-long lines or frames never wrap back into the grid.
         if (!I_de)
            x_q <= '0;
         else if (x_q != '1)
            x_q <= x_q + 1'b1;
         if (vs_rise)
            y_q <= '0;
         else if (line_end && (y_q != '1))
            y_q <= y_q + 1'b1;
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         for (int i = 0; i < ZONE_COLS; i++) begin
            sum_q[i]       <= '0;
            peak_q[i]      <= '0;
            dump_avg_q[i]  <= '0;
            dump_peak_q[i] <= '0;
         end
         dump_row_q <= '0;
      end else begin
         if (row_end) begin
            for (int i = 0; i < ZONE_COLS; i++) begin
               dump_avg_q[i]  <= sum_q[i][SW-1 -: 8];
               dump_peak_q[i] <= peak_q[i];
            end
            dump_row_q <= 10'(y_q >> ZONE_H_LOG2);
         end
         if (row_end || vs_rise) begin
            for (int i = 0; i < ZONE_COLS; i++) begin
               sum_q[i]  <= '0;
               peak_q[i] <= '0;
            end
         end else if (pix_in_grid) begin
            sum_q[pix_col] <= sum_q[pix_col] + SW'(lum_q);
            if (lum_q > peak_q[pix_col])
               peak_q[pix_col] <= lum_q;
         end
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q    <= IDLE;
         col_q      <= '0;
         O_wr       <= 1'b0;
         O_sdbpflag <= 1'b0;
         O_wtaddr   <= '0;
         O_wtdina   <= '0;
      end else begin
         O_wr       <= 1'b0;
         O_sdbpflag <= 1'b0;
         if (state_q == DUMP) begin
            O_wr       <= 1'b1;
            O_sdbpflag <= (addr_d == '0);
            O_wtaddr   <= addr_d;
            O_wtdina   <= {dump_peak_q[col_q], dump_avg_q[col_q]};
            col_q      <= col_q + 1'b1;
            if (col_q == CW'(ZONE_COLS - 1))
               state_q <= IDLE;
         end
         if (row_end) begin
            state_q <= DUMP;
            col_q   <= '0;
         end
      end
   end
endmodule

// File: tb/tb_zone_luma_stats.sv
// tb/tb_zone_luma_stats.sv - scoreboard bench for zone_luma_stats on a reduced 4x4 grid of 8x4-pixel zones
module tb_zone_luma_stats;
   localparam int COLS = 4;
   localparam int ROWS = 4;
   localparam int WL   = 3;
   localparam int HL   = 2;
   localparam int ZW   = 1 << WL;
   localparam int ZH   = 1 << HL;
   localparam int BL   = COLS + 8;
   localparam int MAXW = 48;
   localparam int MAXH = 24;

   logic        I_clk = 1'b0;
   logic        I_rst_n = 1'b0;
   logic        I_vs = 1'b0;
   logic        I_de = 1'b0;
   logic [7:0]  I_r = '0, I_g = '0, I_b = '0;
   logic        O_sdbpflag, O_wr;
   logic [9:0]  O_wtaddr;
   logic [15:0] O_wtdina;

   zone_luma_stats #(
      .ZONE_COLS(COLS), .ZONE_ROWS(ROWS), .ZONE_W_LOG2(WL), .ZONE_H_LOG2(HL)
   ) dut (
      .I_clk(I_clk), .I_rst_n(I_rst_n), .I_vs(I_vs), .I_de(I_de),
      .I_r(I_r), .I_g(I_g), .I_b(I_b),
      .O_sdbpflag(O_sdbpflag), .O_wr(O_wr), .O_wtaddr(O_wtaddr), .O_wtdina(O_wtdina)
   );

   always #5 I_clk = ~I_clk;

   int cyc = 0;
   always @(posedge I_clk) cyc <= cyc + 1;

   int          n_cmp = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;
   logic [9:0]  last_addr = '0;
   logic [15:0] last_data = '0;
   logic [26:0] exp_q[$];
   int          fall_q[$];
   logic [7:0]  pr [0:MAXH-1][0:MAXW-1];
   logic [7:0]  pg [0:MAXH-1][0:MAXW-1];
   logic [7:0]  pb [0:MAXH-1][0:MAXW-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int lum_of(input int r, input int g, input int b);
      int m = r;
      if (g > m) m = g;
      if (b > m) m = b;
      return m;
   endfunction

   task automatic set_px(input int y, input int x, input int r, input int g, input int b);
      pr[y][x] = 8'(r);
      pg[y][x] = 8'(g);
      pb[y][x] = 8'(b);
   endtask

   function automatic int rnd_ch(input int pattern);
      if (pattern == 5)
         return ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 40));
      return int'($urandom_range(0, 255));
   endfunction

   task automatic gen_frame(input int pattern, input int w, input int h);
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++) begin
            case (pattern)
               0: set_px(y, x, 100, 50, 20);
               1: if (x == 10 && y == 1) set_px(y, x, 0, 255, 0); else set_px(y, x, 0, 0, 0);
               2: if (x < ZW && y < ZH / 2) set_px(y, x, 0, 0, 200); else set_px(y, x, 0, 0, 0);
               3: if (x < COLS * ZW && y < ROWS * ZH) set_px(y, x, 10, 3, 7);
                  else set_px(y, x, 255, 255, 255);
               default: set_px(y, x, rnd_ch(pattern), rnd_ch(pattern), rnd_ch(pattern));
            endcase
         end
   endtask

   // Only zone rows whose every line was driven before the next frame start are reported.
   task automatic push_expected(input int nl);
      for (int zr = 0; zr < ROWS; zr++) begin
         if ((zr + 1) * ZH > nl) break;
         for (int zc = 0; zc < COLS; zc++) begin
            int s = 0;
            int pk = 0;
            int addr = zr * COLS + zc;
            logic flag = (addr == 0);
            for (int y = zr * ZH; y < (zr + 1) * ZH; y++)
               for (int x = zc * ZW; x < (zc + 1) * ZW; x++) begin
                  int l = lum_of(pr[y][x], pg[y][x], pb[y][x]);
                  s += l;
                  if (l > pk) pk = l;
               end
            exp_q.push_back({flag, 10'(addr), 8'(pk), 8'(s / (ZW * ZH))});
         end
      end
   endtask

   task automatic step();
      @(posedge I_clk);
      #1;
   endtask

   task automatic drive_frame(input int w, input int nl, input bit chk);
      I_vs = 1'b1;
      repeat (2) step();
      I_vs = 1'b0;
      repeat (4) step();
      for (int y = 0; y < nl; y++) begin
         for (int x = 0; x < w; x++) begin
            I_de = 1'b1;
            I_r = pr[y][x];
            I_g = pg[y][x];
            I_b = pb[y][x];
            step();
         end
         I_de = 1'b0;
         I_r = 8'($urandom);
         I_g = 8'($urandom);
         I_b = 8'($urandom);
         if (chk && (y % ZH) == ZH - 1 && (y / ZH) < ROWS)
            fall_q.push_back(cyc + 1);
         repeat (BL) step();
      end
      repeat (6) step();
   endtask

   initial begin : monitor
      bit prev_wr;
      int burst;
      int f;
      logic [26:0] e;
      prev_wr = 1'b0;
      burst = 0;
      forever begin
         @(negedge I_clk);
         if (!mon_en) begin
            prev_wr = 1'b0;
            burst = 0;
            continue;
         end
         if (O_wr) begin
            if (!prev_wr) begin
               burst = 0;
               if (fall_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL burst_start: unexpected burst at cycle %0d, expected none", cyc);
               end else begin
                  f = fall_q.pop_front();
                  check("first_write_latency", cyc, f + 2);
               end
            end
            burst++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL write: unexpected write addr %0h data %0h, expected none", O_wtaddr, O_wtdina);
            end else begin
               e = exp_q.pop_front();
               check("write", {5'b0, O_sdbpflag, O_wtaddr, O_wtdina}, {5'b0, e});
            end
            last_addr = O_wtaddr;
            last_data = O_wtdina;
         end else begin
            if (prev_wr) check("burst_length", burst, COLS);
            check("idle_hold", {5'b0, O_sdbpflag, O_wtaddr, O_wtdina}, {5'b0, 1'b0, last_addr, last_data});
         end
         prev_wr = O_wr;
      end
   end

   initial begin : main
      repeat (3) @(posedge I_clk);
      #1;
      check("reset_wr", O_wr, 0);
      check("reset_flag", O_sdbpflag, 0);
      check("reset_addr", O_wtaddr, 0);
      check("reset_data", O_wtdina, 0);
      @(negedge I_clk);
      I_rst_n = 1'b1;
      step();
      mon_en = 1'b1;

      gen_frame(0, 32, 16); push_expected(16); drive_frame(32, 16, 1'b1);
      gen_frame(1, 32, 16); push_expected(16); drive_frame(32, 16, 1'b1);
      gen_frame(2, 32, 16); push_expected(16); drive_frame(32, 16, 1'b1);
      gen_frame(3, 40, 20); push_expected(20); drive_frame(40, 20, 1'b1);
      gen_frame(4, 32, 16); push_expected(16); drive_frame(32, 16, 1'b1);
      // Frame aborted by a new frame start two lines into zone row 1.
      gen_frame(4, 32, 16); push_expected(6);  drive_frame(32, 6, 1'b1);
      gen_frame(5, 36, 18); push_expected(18); drive_frame(36, 18, 1'b1);

      // Reset lands on the third write of the zone-row-0 dump.
      gen_frame(4, 32, 16);
      mon_en = 1'b0;
      fork
         drive_frame(32, ZH, 1'b0);
         begin
            int nw = 0;
            bit hit = 1'b0;
            for (int i = 0; i < 3000 && !hit; i++) begin
               @(negedge I_clk);
               if (O_wr) nw++;
               if (nw == 3) begin
                  hit = 1'b1;
                  I_rst_n = 1'b0;
                  #1;
                  check("rst_dump_wr", O_wr, 0);
                  check("rst_dump_flag", O_sdbpflag, 0);
                  check("rst_dump_addr", O_wtaddr, 0);
                  check("rst_dump_data", O_wtdina, 0);
                  repeat (3) @(negedge I_clk);
                  I_rst_n = 1'b1;
               end
            end
            if (!hit) begin
               n_cmp++;
               n_fail++;
               $display("FAIL rst_dump_timeout: saw %0d writes, expected 3", nw);
            end
         end
      join
      step();
      last_addr = '0;
      last_data = '0;
      mon_en = 1'b1;

      for (int k = 0; k < 5; k++) begin
         int w = int'($urandom_range(32, 44));
         int h = int'($urandom_range(16, 22));
         gen_frame((k % 2 == 0) ? 4 : 5, w, h);
         push_expected(h);
         drive_frame(w, h, 1'b1);
      end

      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) step();
      repeat (4) step();
      check("expected_drained", exp_q.size(), 0);
      check("bursts_drained", fall_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/zone_luma_stats.md
# zone_luma_stats

Per-zone backlight statistics engine for the zonal-backlight path. Sits between the LVDS receiver's decoded pixel stream and the SRAM/LED-driver write port. Measures each pixel's luminance as max(R,G,B) and accumulates it into a rectangular zone grid. At the end of each zone row it emits one write per zone: an address plus the packed {peak, average} value, with a frame-start flag on zone 0.

## Interface
- ZONE_COLS, 16, zone columns per frame (power of 2, ≤ 32)
- ZONE_ROWS, 8, zone rows per frame (ZONE_COLS*ZONE_ROWS ≤ 1024)
- ZONE_W_LOG2, 6, log2 of zone width in pixels (64)
- ZONE_H_LOG2, 6, log2 of zone height in lines (64)

- I_clk  input  1  pixel clock; all logic on rising edge
- I_rst_n  input  1  reset, asynchronous, active-low
- I_vs  input  1  vertical sync, active-high; rising edge = frame start
- I_de  input  1  data enable, active-high
- I_r, I_g, I_b  input  8 each  pixel colour, valid when I_de=1
- O_sdbpflag  output  1  one-cycle pulse coincident with the write of address 0
- O_wr  output  1  write strobe, one write per cycle
- O_wtaddr  output  10  zone address = row*ZONE_COLS + col
- O_wtdina  output  16  {peak[7:0], avg[7:0]}

## Operation
- Reset: all outputs 0; counters, accumulators and peak registers cleared; FSM in IDLE.
- Stage 1 (registered): lum = max(R,G,B), de_d, x_d.
- Position tracking:
  - x counts I_de-high cycles and clears when I_de falls.
  - y increments on each I_de falling edge and clears on I_vs rising edge.
  - zone col = x >> ZONE_W_LOG2; zone row = y >> ZONE_H_LOG2.
- Out-of-grid pixels (col ≥ ZONE_COLS or row ≥ ZONE_ROWS) are ignored.
- Stage 2 (accumulate): each column keeps
  - sum (ZONE_W_LOG2+ZONE_H_LOG2+8 = 20 bits; cannot overflow);
  - peak (8 bits, max).
- End of zone row: the I_de falling edge of a line with y[ZONE_H_LOG2-1:0] all ones and row < ZONE_ROWS does three things in one cycle:
  - snapshots all sums and peaks into the dump buffer;
  - clears the accumulators;
  - moves the FSM IDLE→DUMP.
- DUMP: a column index runs 0..ZONE_COLS-1, one write per cycle.
  - avg = sum >> (ZONE_W_LOG2+ZONE_H_LOG2), truncated.
  - O_wtaddr = row*ZONE_COLS + col.
  - After the last column, return to IDLE.
- O_sdbpflag = 1 only on the write whose address is 0.
- VS rising edge mid-frame:
  - partial accumulators are cleared and y resets;
  - a DUMP in progress completes from its snapshot.
- Reset mid-DUMP: writes stop immediately; outputs go to 0.
- I_vs rising and an end-of-row on the same cycle: the snapshot is taken first; accumulators and y are still cleared.

## Timing
- If I_de is first sampled low at edge n, O_wr is high at edges n+2 … n+1+ZONE_COLS, contiguous.
- Horizontal blanking must be ≥ ZONE_COLS+4 cycles. End-of-row events are ≥ 64 lines apart, so DUMPs never overlap.
- Per frame: exactly ZONE_COLS*ZONE_ROWS writes, addresses strictly ascending, one sdbpflag pulse.
- Outputs are registered; O_wtaddr and O_wtdina are held at the last value while O_wr=0.

## Test plan
- Uniform frame, 1024×512 active, RGB=(100,50,20) -> 128 writes, addr 0..127, all O_wtdina=16'h6464; sdbpflag exactly once, on addr 0.
- Black frame with a single pixel of 255 at (x=70, y=5) -> addr 1 = 16'hFF00; all other addresses 16'h0000.
- Zone 0: lines 0–31 at lum 200, lines 32–63 at 0; rest black -> addr 0 = 16'hC864; check that O_wr first rises 2 cycles after the I_de fall of line 63, with 16 contiguous writes.
- 1100-pixel lines and 600 lines, with pixels x≥1024 or y≥512 at 255 and the grid at 10 -> every zone 16'h0A0A; exactly 128 writes.
- I_vs pulsed at line 100 of a frame, then a clean frame -> zone row 0 writes (addr 0..15) complete normally; partial row 1 is discarded; the next frame starts at addr 0 with sdbpflag.
- I_rst_n asserted during the 5th write of a DUMP -> O_wr, O_sdbpflag, O_wtaddr and O_wtdina are 0 asynchronously; after release, the next full frame produces correct values.
